// File: rtl/axis_testpattern_counter_gen.sv
// AXI4-Stream ramp pattern source: START, START+INCR, ... <= END, then wrap, one sample per DIVIDER clocks.
// Optional m_axis_tlast (end-of-ramp marker) is built when TESTPATTERN_TLAST_EN is defined.
module axis_testpattern_counter_gen #(
  parameter int M00_AXIS_TDATA_WIDTH = 32,
  parameter int COUNTER_START        = 0,
  parameter int COUNTER_END          = 255,
  parameter int COUNTER_INCR         = 1,
  parameter int DIVIDER              = 1
) (
  input  logic                            m_axis_aclk,
  input  logic                            m_axis_aresetn,
  input  logic                            enable,
  output logic [M00_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
`ifdef TESTPATTERN_TLAST_EN
  output logic                            m_axis_tlast,
`endif
  input  logic                            m_axis_tready
);

  localparam int W     = M00_AXIS_TDATA_WIDTH;
  localparam int DIV_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIVIDER - 1);
  localparam logic [W-1:0]     START_W = W'(COUNTER_START);
  localparam logic [W-1:0]     INCR_W  = W'(COUNTER_INCR);
  // One extra bit so cnt+INCR cannot overflow when compared against END.
  localparam logic [W:0]       INCR_X  = (W + 1)'(COUNTER_INCR);
  localparam logic [W:0]       END_X   = (W + 1)'(COUNTER_END);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_next;
  logic [W-1:0]     cnt_reg;
  logic [W-1:0]     cnt_next;
  logic             cnt_wrap;
  logic             tick;
  logic             slot_free;
  logic             load;
  logic             release_slot;

  always_comb begin
    cnt_wrap     = ({1'b0, cnt_reg} + INCR_X) > END_X;
    cnt_next     = cnt_wrap ? START_W : (cnt_reg + INCR_W);
    tick         = enable && (div_reg == DIV_MAX);
    slot_free    = !m_axis_tvalid || m_axis_tready;
    // A tick that finds the slot occupied is dropped; cnt stays put so no value is skipped.
    load         = tick && slot_free;
    release_slot = m_axis_tvalid && m_axis_tready && !load;
  end

  always_comb begin
    div_next = div_reg;
    if (!enable) begin
      div_next = '0;
    end else if (div_reg == DIV_MAX) begin
      div_next = '0;
    end else begin
      div_next = div_reg + DIV_W'(1);
    end
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      div_reg <= '0;
      cnt_reg <= START_W;
    end else begin
      div_reg <= div_next;
      if (load) begin
        cnt_reg <= cnt_next;
      end
    end
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else if (load) begin
      m_axis_tdata  <= cnt_reg;
      m_axis_tvalid <= 1'b1;
    end else if (release_slot) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef TESTPATTERN_TLAST_EN
  // Marks the sample whose successor restarts the ramp.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      m_axis_tlast <= 1'b0;
    end else if (load) begin
      m_axis_tlast <= cnt_wrap;
    end
  end
`endif

endmodule

// File: tb/tb_axis_testpattern_counter_gen.sv
// Bench for axis_testpattern_counter_gen: divided ramp, backpressure, enable gating, DIVIDER=1 stream,
// async reset; tlast checks are compiled in when TESTPATTERN_TLAST_EN is defined.
module tb_axis_testpattern_counter_gen;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        en_a, rdy_a, en_b, rdy_b;
  logic [31:0] data_a, data_b;
  logic        valid_a, valid_b;
`ifdef TESTPATTERN_TLAST_EN
  logic        last_a, last_b;
`endif

  int checks = 0;
  int errors = 0;
  int hs_a   = 0;
  int hs_b   = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];

  always #5 clk = ~clk;

  axis_testpattern_counter_gen #(
    .M00_AXIS_TDATA_WIDTH(32), .COUNTER_START(1), .COUNTER_END(10),
    .COUNTER_INCR(1), .DIVIDER(5)
  ) dut_a (
    .m_axis_aclk(clk), .m_axis_aresetn(aresetn), .enable(en_a),
    .m_axis_tdata(data_a), .m_axis_tvalid(valid_a),
`ifdef TESTPATTERN_TLAST_EN
    .m_axis_tlast(last_a),
`endif
    .m_axis_tready(rdy_a)
  );

  axis_testpattern_counter_gen #(
    .M00_AXIS_TDATA_WIDTH(32), .COUNTER_START(1), .COUNTER_END(9),
    .COUNTER_INCR(3), .DIVIDER(1)
  ) dut_b (
    .m_axis_aclk(clk), .m_axis_aresetn(aresetn), .enable(en_b),
    .m_axis_tdata(data_b), .m_axis_tvalid(valid_b),
`ifdef TESTPATTERN_TLAST_EN
    .m_axis_tlast(last_b),
`endif
    .m_axis_tready(rdy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every handshake pops the next expected ramp value.
  always @(negedge clk) begin
    if (aresetn) begin
      if (valid_a && rdy_a) begin
        hs_a++;
        if (q_a.size() == 0) check("sb_a_empty", data_a, 32'hFFFF_FFFF);
        else begin
          logic [31:0] e;
          e = q_a.pop_front();
          check("sb_a_data", data_a, e);
`ifdef TESTPATTERN_TLAST_EN
          check("sb_a_tlast", {31'd0, last_a}, {31'd0, e == 32'd10});
`endif
          $display("A handshake #%0d data=%0d", hs_a, data_a);
        end
      end
      if (valid_b && rdy_b) begin
        hs_b++;
        if (q_b.size() == 0) check("sb_b_empty", data_b, 32'hFFFF_FFFF);
        else begin
          logic [31:0] e;
          e = q_b.pop_front();
          check("sb_b_data", data_b, e);
`ifdef TESTPATTERN_TLAST_EN
          check("sb_b_tlast", {31'd0, last_b}, {31'd0, e == 32'd7});
`endif
          $display("B handshake #%0d data=%0d", hs_b, data_b);
        end
      end
    end
  end

  // Drive A inputs, advance one edge, optionally check tvalid (and tdata when valid is expected).
  task automatic step_a(input logic en, input logic rdy, input logic chk,
                        input logic expv, input logic [31:0] expd, input string name);
    en_a  = en;
    rdy_a = rdy;
    @(posedge clk);
    #1;
    if (chk) begin
      check({name, "_tvalid"}, {31'd0, valid_a}, {31'd0, expv});
      if (expv) check({name, "_tdata"}, data_a, expd);
    end
  endtask

  typedef struct {
    logic        en;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // Expected ramps: A = 1..10 repeating, B = 1,4,7 repeating.
    for (int i = 0; i < 40; i++) begin
      q_a.push_back(32'((i % 10) + 1));
      q_b.push_back(32'(1 + 3 * (i % 3)));
    end
    for (int i = 0; i < 15; i++) begin
      vecs[i].en        = 1'b1;
      vecs[i].rdy       = 1'b1;
      vecs[i].exp_valid = ((i + 1) % 5 == 0);
      vecs[i].exp_data  = 32'((i + 1) / 5);
    end

    aresetn = 1'b0;
    en_a = 1'b0; rdy_a = 1'b1; en_b = 1'b0; rdy_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_a", {31'd0, valid_a}, 32'd0);
    check("rst_data_a", data_a, 32'd0);
    check("rst_valid_b", {31'd0, valid_b}, 32'd0);
    check("rst_data_b", data_b, 32'd0);
`ifdef TESTPATTERN_TLAST_EN
    check("rst_tlast_a", {31'd0, last_a}, 32'd0);
`endif
    aresetn = 1'b1;

    // Free run, DIVIDER=5: edges 1..15, pulses after edges 5, 10, 15.
    for (int i = 0; i < 15; i++) begin
      step_a(vecs[i].en, vecs[i].rdy, 1'b1, vecs[i].exp_valid, vecs[i].exp_data, "freerun");
    end

    // Backpressure for 15 clocks holding sample 3; ticks at edges 20/25/30 are dropped.
    for (int i = 0; i < 15; i++) step_a(1'b1, 1'b0, 1'b1, 1'b1, 32'd3, "bp_hold");
    for (int i = 0; i < 4; i++)  step_a(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, "bp_release");
    step_a(1'b1, 1'b1, 1'b1, 1'b1, 32'd4, "bp_noskip");
    step_a(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, "bp_pulse_end");

    // Disabled with nothing pending, then re-enabled: sample 5 arrives 5 edges later.
    for (int i = 0; i < 25; i++) step_a(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, "dis_idle");
    for (int i = 0; i < 4; i++)  step_a(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, "reen_wait");
    step_a(1'b1, 1'b1, 1'b1, 1'b1, 32'd5, "reen_first");

    // Disable while a sample is pending under backpressure: tvalid must survive.
    for (int i = 0; i < 10; i++) step_a(1'b0, 1'b0, 1'b1, 1'b1, 32'd5, "dis_pending");
    step_a(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, "dis_accept");

    // Long free run through the 10 -> 1 wrap (values 6..10,1..7), scoreboard checks data.
    for (int i = 0; i < 62; i++) step_a(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, "wrap");
    step_a(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, "wrap_idle");
    check("hs_count_a", 32'(hs_a), 32'd17);

    // DIVIDER=1, INCR=3: back-to-back 1,4,7,1,... with tvalid continuously high.
    for (int i = 0; i < 12; i++) begin
      en_b = 1'b1;
      @(posedge clk);
      #1;
      check("b_stream_valid", {31'd0, valid_b}, 32'd1);
    end
    en_b = 1'b0;
    @(posedge clk);
    #1;
    check("b_stop_valid", {31'd0, valid_b}, 32'd0);
    check("hs_count_b", 32'(hs_b), 32'd12);

    // Asynchronous reset between clock edges with samples in flight.
    en_a = 1'b1;
    en_b = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    aresetn = 1'b0;
    #1;
    check("async_rst_valid_b", {31'd0, valid_b}, 32'd0);
    check("async_rst_data_b", data_b, 32'd0);
    check("async_rst_data_a", data_a, 32'd0);
    check("hs_count_b_final", 32'(hs_b), 32'd13);
    en_a = 1'b0;
    en_b = 1'b0;
    @(posedge clk);
    #1;
    check("rst_hold_valid_b", {31'd0, valid_b}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
